// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl_if
// Brief    : Valid/ready byte hand-off between the UART receiver and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : 16x-oversampling UART receiver with 3-sample majority vote and a
//            valid/ready byte output. Optional parity via macro UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int CLKS_PER_TICK = 27,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_ODD    = 0
) (
    input  wire                  sample_clk,
    input  wire                  rst_n,
    input  wire                  RsRx,
    uart_rx_frame_ctrl_if.master rx,
    output logic                 frame_err,
    output logic                 par_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                 c_cnt_w    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(CLKS_PER_TICK - 1);
    localparam logic [2:0]         c_bit_last = 3'(DATA_BITS - 1);

    if (CLKS_PER_TICK < 2) begin : g_chk_clks_per_tick
        $error("CLKS_PER_TICK must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_data_bits
        $error("DATA_BITS must be within 5..8");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_chk_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [3:0]             r_tick_idx;
    logic                   r_s7;
    logic                   r_s8;
    logic [2:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;
`ifdef UART_PARITY_EN
    logic                   r_par_bad;
    logic                   r_par_err;
`endif

    logic w_rxs;
    logic w_tick;
    logic w_vote_now;
    logic w_vote;
    logic w_can_load;

    assign w_rxs      = r_sync2;
    assign w_tick     = (r_cnt == c_cnt_max);
    assign w_vote_now = w_tick && (r_tick_idx == 4'd9);
    assign w_vote     = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    assign w_can_load = !r_rx_valid || rx.rx_ready;

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= '0;
            r_tick_idx  <= 4'd0;
            r_s7        <= 1'b1;
            r_s8        <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bad   <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_sync1     <= RsRx;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_err   <= 1'b0;
`endif

            // Counters sit at zero in IDLE so tick phase is anchored to the start edge
            if (r_state == S_IDLE) begin
                r_cnt      <= '0;
                r_tick_idx <= 4'd0;
            end else if (w_tick) begin
                r_cnt      <= '0;
                r_tick_idx <= r_tick_idx + 4'd1;
            end else begin
                r_cnt      <= r_cnt + c_cnt_w'(1);
            end

            if (w_tick && (r_tick_idx == 4'd7)) r_s7 <= w_rxs;
            if (w_tick && (r_tick_idx == 4'd8)) r_s8 <= w_rxs;

            if (r_rx_valid && rx.rx_ready) r_rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_vote_now) begin
                        if (w_vote) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
`ifdef UART_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (w_vote_now) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bit_last) begin
`ifdef UART_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_vote_now) begin
                        r_par_bad <= (w_vote != ((^r_shift) ^ 1'(PARITY_ODD)));
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_vote_now) begin
                        if (w_vote) begin
                            // Return to IDLE mid-stop so the next start edge is caught early
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (w_can_load) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun  <= 1'b1;
                            end
`ifdef UART_PARITY_EN
                            r_par_err <= r_par_bad;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BRK;
                        end
                    end
                end
                S_BRK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_data  = r_rx_data;
    assign rx.rx_valid = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign busy        = r_busy;
`ifdef UART_PARITY_EN
    assign par_err     = r_par_err;
`else
    assign par_err     = 1'b0;
`endif

endmodule
`default_nettype wire
